// File: rtl/line_ram_mp.sv
// Shared line-wide word RAM serving several requesters through round-robin
// arbitration, with byte strobes, range checking and a fixed-latency response pipe.
module line_ram_mp #(
   parameter  int unsigned WORD_WIDTH   = 32,
   parameter  int unsigned RAM_DEPTH    = 32768,
   parameter  int unsigned LINE_WIDTH   = 128,
   parameter  int unsigned NUM_PORTS    = 2,
   parameter  int unsigned READ_LATENCY = 1,
   localparam int unsigned ADDR_W       = $clog2(RAM_DEPTH),
   localparam int unsigned STRB_W       = LINE_WIDTH / 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS-1:0]            req_valid_i,
   output logic [NUM_PORTS-1:0]            req_ready_o,
   input  logic [NUM_PORTS-1:0]            req_we_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr_i,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata_i,
   input  logic [NUM_PORTS*STRB_W-1:0]     req_wstrb_i,
   output logic [NUM_PORTS-1:0]            rsp_valid_o,
   output logic [LINE_WIDTH-1:0]           rsp_rdata_o,
   output logic                            rsp_err_o
);

   localparam int unsigned WPL   = LINE_WIDTH / WORD_WIDTH;
   localparam int unsigned BPW   = WORD_WIDTH / 8;
   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CW    = ADDR_W + 1;

   typedef struct packed {
      logic [NUM_PORTS-1:0]  vld;
      logic                  err;
      logic [LINE_WIDTH-1:0] rdata;
   } stage_t;

   logic [WORD_WIDTH-1:0] mem [RAM_DEPTH];
   stage_t                pipe [READ_LATENCY];

   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      gnt_idx;
   logic [PTR_W-1:0]      next_ptr;
   logic [PTR_W:0]        scan;
   logic                  any_gnt;
   logic [NUM_PORTS-1:0]  gnt;

   logic                  sel_we;
   logic [ADDR_W-1:0]     sel_addr;
   logic [ADDR_W-1:0]     line_base;
   logic [LINE_WIDTH-1:0] sel_wdata;
   logic [STRB_W-1:0]     sel_wstrb;
   logic [CW-1:0]         line_end;
   logic                  oor;
   logic [LINE_WIDTH-1:0] rd_line;

   // Round-robin search starting at rr_ptr; nothing is granted while in reset
   always_comb begin
      gnt_idx = '0;
      any_gnt = 1'b0;
      scan    = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan >= (PTR_W+1)'(NUM_PORTS)) begin
            scan = scan - (PTR_W+1)'(NUM_PORTS);
         end
         if (!any_gnt && req_valid_i[scan[PTR_W-1:0]]) begin
            any_gnt = 1'b1;
            gnt_idx = scan[PTR_W-1:0];
         end
      end
      if (rst_i) begin
         any_gnt = 1'b0;
      end
   end

   assign gnt         = any_gnt ? (NUM_PORTS'(1) << gnt_idx) : '0;
   assign req_ready_o = gnt;
   assign next_ptr    = ({1'b0, gnt_idx} == (PTR_W+1)'(NUM_PORTS - 1)) ? '0
                                                                        : gnt_idx + PTR_W'(1);

   assign sel_we    = req_we_i[gnt_idx];
   assign sel_addr  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata_i[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
   assign sel_wstrb = req_wstrb_i[gnt_idx*STRB_W +: STRB_W];

   // Line must fit entirely below RAM_DEPTH (depth need not be a power of two)
   assign line_base = sel_addr & ~ADDR_W'(WPL - 1);
   assign line_end  = CW'(line_base) + CW'(WPL);
   assign oor       = line_end > CW'(RAM_DEPTH);

   always_comb begin
      rd_line = '0;
      if (!oor) begin
         for (int unsigned w = 0; w < WPL; w++) begin
            rd_line[w*WORD_WIDTH +: WORD_WIDTH] = mem[line_base + ADDR_W'(w)];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         rr_ptr <= next_ptr;
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (any_gnt && sel_we && !oor) begin
         for (int unsigned w = 0; w < WPL; w++) begin
            for (int unsigned j = 0; j < BPW; j++) begin
               if (sel_wstrb[w*BPW + j]) begin
                  mem[line_base + ADDR_W'(w)][j*8 +: 8] <= sel_wdata[w*WORD_WIDTH + j*8 +: 8];
               end
            end
         end
      end
   end

   // Response pipe; empty slots carry zero data so outputs idle at 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0].vld   <= gnt;
         pipe[0].err   <= any_gnt && oor;
         pipe[0].rdata <= (any_gnt && !sel_we) ? rd_line : '0;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign rsp_valid_o = pipe[READ_LATENCY-1].vld;
   assign rsp_err_o   = pipe[READ_LATENCY-1].err;
   assign rsp_rdata_o = pipe[READ_LATENCY-1].rdata;

endmodule

// File: tb/tb_line_ram_mp.sv
// Directed bench for line_ram_mp: three instances cover latency 1, latency 3 with a
// non-power-of-two depth, and latency 4 for reset while a read is in flight.
module tb_line_ram_mp;

   logic clk;
   logic rst;

   // u0: depth 72, latency 1
   logic [1:0]   v0, we0, rdy0, rv0;
   logic [13:0]  addr0;
   logic [255:0] wd0;
   logic [31:0]  st0;
   logic [127:0] rd0;
   logic         er0;

   // u1: depth 24, latency 3
   logic [1:0]   v1, we1, rdy1, rv1;
   logic [9:0]   addr1;
   logic [255:0] wd1;
   logic [31:0]  st1;
   logic [127:0] rd1;
   logic         er1;

   // u2: depth 32, latency 4
   logic [1:0]   v2, we2, rdy2, rv2;
   logic [9:0]   addr2;
   logic [255:0] wd2;
   logic [31:0]  st2;
   logic [127:0] rd2;
   logic         er2;

   int total;
   int bad;

   localparam logic [127:0] L0    = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] L0_AA = 128'h44444444_33333333_22222222_111111AA;
   localparam logic [127:0] A0    = 128'h00000003_00000002_00000001_00000000;
   localparam logic [127:0] A4    = 128'h00000013_00000012_00000011_00000010;
   localparam logic [127:0] A8    = 128'h00000023_00000022_00000021_00000020;
   localparam logic [127:0] A14   = 128'h00000053_00000052_00000051_00000050;

   line_ram_mp #(.RAM_DEPTH(72), .READ_LATENCY(1)) u0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
      .req_addr_i(addr0), .req_wdata_i(wd0), .req_wstrb_i(st0),
      .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(er0));

   line_ram_mp #(.RAM_DEPTH(24), .READ_LATENCY(3)) u1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1),
      .req_addr_i(addr1), .req_wdata_i(wd1), .req_wstrb_i(st1),
      .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(er1));

   line_ram_mp #(.RAM_DEPTH(32), .READ_LATENCY(4)) u2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(we2),
      .req_addr_i(addr2), .req_wdata_i(wd2), .req_wstrb_i(st2),
      .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .rsp_err_o(er2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      v0 = '0; we0 = '0; addr0 = '0; wd0 = '0; st0 = '0;
      v1 = '0; we1 = '0; addr1 = '0; wd1 = '0; st1 = '0;
      v2 = '0; we2 = '0; addr2 = '0; wd2 = '0; st2 = '0;
      tick;
      tick;

      // Reset: no grants even with valid requests, outputs idle
      v0 = 2'b11;
      v2 = 2'b11;
      #1;
      chk("rst_rdy0", 128'(rdy0), 128'(2'b00));
      chk("rst_rdy2", 128'(rdy2), 128'(2'b00));
      chk("rst_rv0", 128'(rv0), 128'(2'b00));
      chk("rst_rd0", rd0, 128'h0);
      chk("rst_er0", 128'(er0), 128'(1'b0));
      chk("rst_rv1", 128'(rv1), 128'(2'b00));
      v0 = '0;
      v2 = '0;
      tick;
      rst = 1'b0;

      // Arbitration on u0: both ports valid for 4 grants, pointer starts at 0
      we0 = 2'b00;
      addr0 = '0;
      v0 = 2'b11;
      #1;
      chk("arb_g0", 128'(rdy0), 128'(2'b01));
      tick;
      chk("arb_g1", 128'(rdy0), 128'(2'b10));
      chk("arb_r0", 128'(rv0), 128'(2'b01));
      tick;
      chk("arb_g2", 128'(rdy0), 128'(2'b01));
      chk("arb_r1", 128'(rv0), 128'(2'b10));
      tick;
      chk("arb_g3", 128'(rdy0), 128'(2'b10));
      chk("arb_r2", 128'(rv0), 128'(2'b01));
      tick;
      v0 = 2'b00;
      chk("arb_r3", 128'(rv0), 128'(2'b10));
      tick;
      chk("idle_rv0", 128'(rv0), 128'(2'b00));
      chk("idle_rd0", rd0, 128'h0);
      chk("idle_er0", 128'(er0), 128'(1'b0));

      // Preload line 0x40, then read it back next cycle via addr 0x41
      v0 = 2'b01; we0 = 2'b01; addr0[6:0] = 7'h40; wd0[127:0] = L0; st0[15:0] = 16'hFFFF;
      #1;
      chk("pre_rdy", 128'(rdy0), 128'(2'b01));
      tick;
      chk("pre_rv", 128'(rv0), 128'(2'b01));
      chk("pre_rd", rd0, 128'h0);
      we0 = 2'b00; addr0[6:0] = 7'h41;
      tick;
      chk("rd_rv", 128'(rv0), 128'(2'b01));
      chk("rd_data", rd0, L0);
      chk("rd_err", 128'(er0), 128'(1'b0));

      // Byte-strobe write of byte 0 only, then read through port 1
      we0 = 2'b01; addr0[6:0] = 7'h42; wd0[127:0] = {16{8'hAA}}; st0[15:0] = 16'h0001;
      tick;
      chk("bs_rv", 128'(rv0), 128'(2'b01));
      chk("bs_rd", rd0, 128'h0);
      v0 = 2'b10; we0 = 2'b00; addr0[13:7] = 7'h40;
      #1;
      chk("bs_rdy1", 128'(rdy0), 128'(2'b10));
      tick;
      chk("bs_rv1", 128'(rv0), 128'(2'b10));
      chk("bs_data", rd0, L0_AA);

      // All-zero strobe still responds and changes nothing
      v0 = 2'b01; we0 = 2'b01; addr0[6:0] = 7'h40; wd0[127:0] = {16{8'hFF}}; st0[15:0] = 16'h0000;
      tick;
      chk("zs_rv", 128'(rv0), 128'(2'b01));
      we0 = 2'b00;
      tick;
      chk("zs_data", rd0, L0_AA);

      // Out of range on u0: line 0x48 in a 72-word RAM
      addr0[6:0] = 7'h48;
      tick;
      v0 = 2'b00;
      chk("oor0_rv", 128'(rv0), 128'(2'b01));
      chk("oor0_err", 128'(er0), 128'(1'b1));
      chk("oor0_rd", rd0, 128'h0);
      tick;
      chk("oor0_idle_err", 128'(er0), 128'(1'b0));

      // u1 preload: lines 0x0, 0x4, 0x8, 0x14 back to back, then drain
      v1 = 2'b01; we1 = 2'b01; st1[15:0] = 16'hFFFF;
      addr1[4:0] = 5'h00; wd1[127:0] = A0;
      tick;
      addr1[4:0] = 5'h04; wd1[127:0] = A4;
      tick;
      addr1[4:0] = 5'h08; wd1[127:0] = A8;
      tick;
      addr1[4:0] = 5'h14; wd1[127:0] = A14;
      tick;
      v1 = 2'b00;
      tick; tick; tick; tick;

      // Latency 3: back-to-back reads of 0x0, 0x4, 0x8
      we1 = 2'b00; addr1[4:0] = 5'h00; v1 = 2'b01;
      tick;
      chk("lat_e1", 128'(rv1), 128'(2'b00));
      addr1[4:0] = 5'h04;
      tick;
      chk("lat_e2", 128'(rv1), 128'(2'b00));
      addr1[4:0] = 5'h08;
      tick;
      v1 = 2'b00;
      chk("lat_r0_v", 128'(rv1), 128'(2'b01));
      chk("lat_r0_d", rd1, A0);
      tick;
      chk("lat_r4_v", 128'(rv1), 128'(2'b01));
      chk("lat_r4_d", rd1, A4);
      tick;
      chk("lat_r8_v", 128'(rv1), 128'(2'b01));
      chk("lat_r8_d", rd1, A8);
      tick;
      chk("lat_end_v", 128'(rv1), 128'(2'b00));
      chk("lat_end_d", rd1, 128'h0);

      // Out of range in a 24-word RAM: read and write at 0x18, then boundary line 0x14
      v1 = 2'b10; we1 = 2'b00; addr1[9:5] = 5'h18;
      tick;
      v1 = 2'b01; we1 = 2'b01; addr1[4:0] = 5'h18; wd1[127:0] = {16{8'hFF}}; st1[15:0] = 16'hFFFF;
      tick;
      we1 = 2'b00; addr1[4:0] = 5'h14;
      tick;
      chk("oor_rd_v", 128'(rv1), 128'(2'b10));
      chk("oor_rd_err", 128'(er1), 128'(1'b1));
      chk("oor_rd_data", rd1, 128'h0);
      addr1[4:0] = 5'h00;
      tick;
      v1 = 2'b00;
      chk("oor_wr_v", 128'(rv1), 128'(2'b01));
      chk("oor_wr_err", 128'(er1), 128'(1'b1));
      tick;
      chk("last_line_err", 128'(er1), 128'(1'b0));
      chk("last_line_data", rd1, A14);
      tick;
      chk("line0_kept", rd1, A0);

      // Reset while a latency-4 read is in flight on u2 (pointer left at 1)
      v2 = 2'b01; we2 = 2'b00; addr2 = '0;
      tick;
      v2 = 2'b00;
      chk("mid_e1", 128'(rv2), 128'(2'b00));
      tick;
      chk("mid_e2", 128'(rv2), 128'(2'b00));
      rst = 1'b1;
      v2 = 2'b11;
      #1;
      chk("mid_rst_rdy", 128'(rdy2), 128'(2'b00));
      tick;
      rst = 1'b0;
      #1;
      chk("mid_e3", 128'(rv2), 128'(2'b00));
      chk("mid_next_gnt", 128'(rdy2), 128'(2'b01));
      v2 = 2'b00;
      tick;
      chk("mid_e4", 128'(rv2), 128'(2'b00));
      chk("mid_e4_d", rd2, 128'h0);
      tick;
      chk("mid_e5", 128'(rv2), 128'(2'b00));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
